// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
// Holds the ResultSrc encodings, the funct3 access-size encodings, the
// controller FSM state type and a helper that maps funct3 to an access size.
package mem_access_ctrl_pkg;

    // Writeback result select carried from EX/MEM to MEM/WB
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrc_t;

    // funct3 load/store size and signedness encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } accessSize_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Unrecognised funct3 values fall back to a word access
    function automatic accessSize_t decodeSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: decodeSize = SZ_B;
            F3_H, F3_HU: decodeSize = SZ_H;
            F3_W:        decodeSize = SZ_W;
            default:     decodeSize = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the 32-bit
// memory read word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata    - raw word returned by data memory
//   addrLo   - byte offset within the word (address bits [1:0])
//   funct3   - load size/sign encoding
//   loadData - register-file-ready load value
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        case (addrLo)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        // Aligned halfwords only ever sit at offset 0 or 2
        halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
            F3_BU:   loadData = {24'h0, byteSel};
            F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
            F3_HU:   loadData = {16'h0, halfSel};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller with MEM/WB pipeline register.
// Issues load/store requests to a handshaked data memory, stalls the
// pipeline while a request is outstanding, aborts after TIMEOUT stalled
// cycles, rejects misaligned accesses and forms the writeback fields.
// Ports:
//   clock, reset                - clock, synchronous active-low reset
//   RegWriteM..RdM              - MEM-stage control/data from EX/MEM
//   dmem_req/we/addr/wdata/be   - memory request (word-aligned)
//   dmem_ack, dmem_rdata        - memory completion and read data
//   StallM                      - freezes IF..MEM registers while high
//   RegWriteW..RdW              - MEM/WB register outputs
//   misaligned_err, timeout_err - one-cycle registered error pulses
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        memwriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic        misaligned_err,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [CNT_W-1:0] waitCnt;

    // Request copy held stable for the whole WAIT phase
    logic        regWe;
    logic [31:0] regAddr;
    logic [31:0] regWdata;
    logic [3:0]  regBe;
    logic [2:0]  regFunct3;
    logic [1:0]  regAddrLo;

    logic        isAccess;
    logic        misaligned;
    accessSize_t sizeM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic [3:0]  beM;
    logic        timeoutHit;
    logic        done;
    logic [2:0]  curFunct3;
    logic [1:0]  curAddrLo;
    logic [31:0] loadData;

    // Decode of the instruction currently in MEM
    always_comb begin
        isAccess   = memwriteM || (ResultSrcM == RES_MEM);
        sizeM      = decodeSize(funct3M);
        misaligned = ((sizeM == SZ_H) && ALUResultM[0]) ||
                     ((sizeM == SZ_W) && (ALUResultM[1:0] != 2'b00));
        addrM      = {ALUResultM[31:2], 2'b00};
        case (sizeM)
            SZ_B: begin
                wdataM = {4{WriteDataM[7:0]}};
                beM    = 4'b0001 << ALUResultM[1:0];
            end
            SZ_H: begin
                wdataM = {2{WriteDataM[15:0]}};
                beM    = 4'b0011 << ALUResultM[1:0];
            end
            default: begin
                wdataM = WriteDataM;
                beM    = 4'b1111;
            end
        endcase
    end

    assign timeoutHit = (state == S_WAIT) && (waitCnt == CNT_W'(TIMEOUT));

    // Request/stall outputs: IDLE drives straight from the M decode so a
    // zero-wait memory completes in the same cycle; WAIT replays the copy.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = addrM;
        dmem_wdata = wdataM;
        dmem_be    = beM;
        StallM     = 1'b0;
        done       = 1'b0;
        curFunct3  = funct3M;
        curAddrLo  = ALUResultM[1:0];
        if (state == S_WAIT) begin
            dmem_addr  = regAddr;
            dmem_wdata = regWdata;
            dmem_be    = regBe;
            curFunct3  = regFunct3;
            curAddrLo  = regAddrLo;
        end
        if (reset) begin
            if (state == S_IDLE) begin
                if (isAccess && !misaligned) begin
                    dmem_req = 1'b1;
                    dmem_we  = memwriteM;
                    StallM   = !dmem_ack;
                    done     = dmem_ack;
                end
            end else if (!timeoutHit) begin
                dmem_req = 1'b1;
                dmem_we  = regWe;
                StallM   = !dmem_ack;
                done     = dmem_ack;
            end
            // On timeout the request is dropped and the pipeline released
            // so the killed instruction leaves MEM as a bubble.
        end
    end

    mem_access_ctrl_load_align loadAlign (
        .rdata    (dmem_rdata),
        .addrLo   (curAddrLo),
        .funct3   (curFunct3),
        .loadData (loadData)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= S_IDLE;
            waitCnt        <= '0;
            RegWriteW      <= 1'b0;
            ResultSrcW     <= 2'b00;
            ALUResultW     <= 32'h0;
            ReadDataW      <= 32'h0;
            RdW            <= 5'd0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            misaligned_err <= (state == S_IDLE) && isAccess && misaligned;
            timeout_err    <= timeoutHit;

            case (state)
                S_IDLE: begin
                    if (isAccess && !misaligned && !dmem_ack) begin
                        state     <= S_WAIT;
                        waitCnt   <= CNT_W'(1);
                        regWe     <= memwriteM;
                        regAddr   <= addrM;
                        regWdata  <= wdataM;
                        regBe     <= beM;
                        regFunct3 <= funct3M;
                        regAddrLo <= ALUResultM[1:0];
                    end
                end
                default: begin
                    if (timeoutHit || dmem_ack) begin
                        state   <= S_IDLE;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
            endcase

            // MEM/WB: pass the instruction on completion or when it needs no
            // memory; otherwise (stalled, misaligned, aborted) insert a bubble.
            if (done || ((state == S_IDLE) && !isAccess)) begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
            end else begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 2'b00;
            end
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadData;
            RdW        <= RdM;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (instantiated with TIMEOUT=4).
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        RegWriteM;
    logic        memwriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic        misaligned_err;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .RegWriteM      (RegWriteM),
        .memwriteM      (memwriteM),
        .ResultSrcM     (ResultSrcM),
        .funct3M        (funct3M),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .RdM            (RdM),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .StallM         (StallM),
        .RegWriteW      (RegWriteW),
        .ResultSrcW     (ResultSrcW),
        .ALUResultW     (ALUResultW),
        .ReadDataW      (ReadDataW),
        .RdW            (RdW),
        .misaligned_err (misaligned_err),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setM(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
        RegWriteM  = rw;
        memwriteM  = mw;
        ResultSrcM = rs;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        RdM        = rd;
    endtask

    task automatic setIdle();
        setM(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        setIdle();

        // Reset: a load is presented but must not be issued
        setM(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd3);
        tick();
        tick();
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_stall", StallM, 0);
        check("rst_regwrite", RegWriteW, 0);
        check("rst_resultsrc", ResultSrcW, 0);
        check("rst_alures", ALUResultW, 0);
        check("rst_readdata", ReadDataW, 0);
        check("rst_rd", RdW, 0);
        check("rst_mis", misaligned_err, 0);
        check("rst_to", timeout_err, 0);
        setIdle();
        tick();
        reset = 1'b1;
        tick();

        // LW 0x100 acked in the request cycle
        setM(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd5);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("lw_req", dmem_req, 1);
        check("lw_we", dmem_we, 0);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be", dmem_be, 4'hF);
        check("lw_stall", StallM, 0);
        tick();
        check("lw_readdata", ReadDataW, 32'hDEADBEEF);
        check("lw_regwrite", RegWriteW, 1);
        check("lw_rd", RdW, 5);
        check("lw_resultsrc", ResultSrcW, 2'b01);

        // SB 0x103 data 0xA5, ack on the fourth cycle
        setM(1'b0, 1'b1, 2'b00, 3'b000, 32'h103, 32'h000000A5, 5'd0);
        dmem_ack = 1'b0;
        #1;
        check("sb_req_c0", dmem_req, 1);
        check("sb_we_c0", dmem_we, 1);
        check("sb_addr_c0", dmem_addr, 32'h100);
        check("sb_wdata_c0", dmem_wdata, 32'hA5A5A5A5);
        check("sb_be_c0", dmem_be, 4'b1000);
        check("sb_stall_c0", StallM, 1);
        tick();
        // Disturb M operands: the outstanding request must not follow them
        ALUResultM = 32'h200;
        WriteDataM = 32'h00000011;
        #1;
        check("sb_stall_c1", StallM, 1);
        check("sb_addr_c1", dmem_addr, 32'h100);
        check("sb_wdata_c1", dmem_wdata, 32'hA5A5A5A5);
        check("sb_be_c1", dmem_be, 4'b1000);
        check("sb_we_c1", dmem_we, 1);
        tick();
        check("sb_stall_c2", StallM, 1);
        check("sb_req_c2", dmem_req, 1);
        check("sb_wdata_c2", dmem_wdata, 32'hA5A5A5A5);
        tick();
        dmem_ack = 1'b1;
        #1;
        check("sb_stall_c3", StallM, 0);
        check("sb_req_c3", dmem_req, 1);
        check("sb_be_c3", dmem_be, 4'b1000);
        tick();
        setIdle();
        #1;
        check("sb_regwrite", RegWriteW, 0);
        check("sb_after_stall", StallM, 0);
        check("sb_after_req", dmem_req, 0);

        // LH / LHU / LB from 0x80010000
        setM(1'b1, 1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 5'd7);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80010000;
        #1;
        check("lh_be", dmem_be, 4'b1100);
        check("lh_stall", StallM, 0);
        tick();
        check("lh_readdata", ReadDataW, 32'hFFFF8001);
        check("lh_regwrite", RegWriteW, 1);
        funct3M = 3'b101;
        tick();
        check("lhu_readdata", ReadDataW, 32'h00008001);
        funct3M = 3'b000;
        ALUResultM = 32'h103;
        #1;
        check("lb_be", dmem_be, 4'b1000);
        tick();
        check("lb_readdata", ReadDataW, 32'hFFFFFF80);
        funct3M = 3'b100;
        ALUResultM = 32'h102;
        tick();
        check("lbu_readdata", ReadDataW, 32'h00000001);

        // SH 0x102 and SW 0x104, acked immediately
        setM(1'b0, 1'b1, 2'b00, 3'b001, 32'h102, 32'h1234BEEF, 5'd0);
        #1;
        check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        check("sh_be", dmem_be, 4'b1100);
        check("sh_addr", dmem_addr, 32'h100);
        tick();
        setM(1'b0, 1'b1, 2'b00, 3'b010, 32'h104, 32'h12345678, 5'd0);
        #1;
        check("sw_wdata", dmem_wdata, 32'h12345678);
        check("sw_be", dmem_be, 4'hF);
        check("sw_addr", dmem_addr, 32'h104);
        tick();

        // Misaligned LW 0x101
        setM(1'b1, 1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 5'd9);
        dmem_ack = 1'b0;
        #1;
        check("mis_req", dmem_req, 0);
        check("mis_stall", StallM, 0);
        tick();
        check("mis_err", misaligned_err, 1);
        check("mis_regwrite", RegWriteW, 0);
        // Unrecognised funct3 behaves as a word access
        setM(1'b0, 1'b1, 2'b00, 3'b011, 32'h102, 32'h0, 5'd0);
        #1;
        check("f3bad_req", dmem_req, 0);
        tick();
        check("f3bad_err", misaligned_err, 1);
        setIdle();
        tick();
        check("mis_err_clear", misaligned_err, 0);

        // Stray ack with no access is ignored, ALU op passes through
        setM(1'b1, 1'b0, 2'b00, 3'b000, 32'h55, 32'h0, 5'd4);
        dmem_ack = 1'b1;
        #1;
        check("stray_req", dmem_req, 0);
        check("stray_stall", StallM, 0);
        tick();
        check("stray_regwrite", RegWriteW, 1);
        check("stray_alures", ALUResultW, 32'h55);
        check("stray_rd", RdW, 4);

        // Timeout: store never acked, TIMEOUT=4
        setM(1'b1, 1'b1, 2'b00, 3'b010, 32'h200, 32'h12345678, 5'd6);
        dmem_ack = 1'b0;
        #1;
        check("to_stall_c0", StallM, 1);
        check("to_req_c0", dmem_req, 1);
        for (int c = 1; c < 4; c++) begin
            tick();
            check("to_stall_wait", StallM, 1);
            check("to_req_wait", dmem_req, 1);
            check("to_regwrite_wait", RegWriteW, 0);
        end
        tick();
        check("to_stall_abort", StallM, 0);
        check("to_req_abort", dmem_req, 0);
        check("to_err_early", timeout_err, 0);
        tick();
        setIdle();
        #1;
        check("to_err", timeout_err, 1);
        check("to_regwrite", RegWriteW, 0);
        check("to_req_after", dmem_req, 0);
        tick();
        check("to_err_clear", timeout_err, 0);

        // Reset while waiting abandons the access
        setM(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd8);
        dmem_rdata = 32'hCAFEF00D;
        #1;
        check("rw_stall_c0", StallM, 1);
        tick();
        check("rw_stall_c1", StallM, 1);
        reset = 1'b0;
        #1;
        check("rw_req_inrst", dmem_req, 0);
        check("rw_stall_inrst", StallM, 0);
        tick();
        check("rw_req", dmem_req, 0);
        check("rw_stall", StallM, 0);
        check("rw_regwrite", RegWriteW, 0);
        check("rw_resultsrc", ResultSrcW, 0);
        check("rw_alures", ALUResultW, 0);
        check("rw_readdata", ReadDataW, 0);
        check("rw_rd", RdW, 0);
        setIdle();
        reset = 1'b1;
        #1;
        check("rw_req_post", dmem_req, 0);
        check("rw_stall_post", StallM, 0);
        tick();
        check("rw_to_post", timeout_err, 0);
        check("rw_regwrite_post", RegWriteW, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max wait cycles for dmem_ack before abort.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 RegWriteM, memwriteM  input  1 each  MEM-stage control from the EX/MEM register.
REQ-005 ResultSrcM  input  2  result select: 00 ALU, 01 memory load, 10 PC+4.
REQ-006 funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM, WriteDataM  input  32 each  byte address / store data; RdM input 5 destination register.
REQ-008 dmem_req, dmem_we  output  1 each  memory request / write qualifier.
REQ-009 dmem_addr  output 32  word-aligned address; dmem_wdata output 32; dmem_be output 4 byte enables.
REQ-010 dmem_ack  input  1  memory completion; dmem_rdata input 32 valid with ack.
REQ-011 StallM  output  1  freezes IF..MEM pipeline registers while high.
REQ-012 RegWriteW out 1, ResultSrcW out 2, ALUResultW out 32, ReadDataW out 32, RdW out 5: MEM/WB register.
REQ-013 misaligned_err, timeout_err  output  1 each  one-cycle registered error pulses.

Function
REQ-014 Access = memwriteM (store) or ResultSrcM==01 (load); store has priority if both set.
REQ-015 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0; no request issued, StallM low.
REQ-016 FSM states IDLE, WAIT; IDLE: aligned access drives dmem_req=1 combinationally same cycle.
REQ-017 IDLE with dmem_ack=1 in the request cycle: zero-wait completion, stays IDLE, StallM low.
REQ-018 IDLE with dmem_ack=0: StallM high, request fields registered, transition to WAIT.
REQ-019 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held stable from registered copy until ack.
REQ-020 WAIT with ack: StallM low that cycle, return to IDLE, W stage captures result.
REQ-021 WAIT cycle counter increments per non-ack cycle; at TIMEOUT drop req, pulse timeout_err, kill instruction, IDLE.
REQ-022 dmem_addr = {ALUResultM[31:2],2'b00}; stores: SB replicate byte x4, be=0001<<addr[1:0]; SH replicate half x2, be=0011<<addr[1:0]; SW be=1111.
REQ-023 Loads: dmem_we=0, be per REQ-022 size; data selected by addr[1:0], sign-extended for B/H, zero-extended for BU/HU.
REQ-024 W register update every cycle: on completion/non-access cycle copy M fields; ReadDataW from extracted load data.
REQ-025 While StallM high, misaligned or timed-out: W gets bubble (RegWriteW=0, ResultSrcW=00), other W fields don't-care.
REQ-026 Misaligned/aborted store never asserts dmem_req; misaligned load never writes register file.
REQ-027 dmem_ack in IDLE without access ignored; unrecognised funct3 treated as W.

Reset
REQ-028 reset low at posedge: state IDLE, counter 0, all W outputs 0, error pulses 0.
REQ-029 Reset mid-WAIT abandons access immediately; dmem_req low the next cycle, no W writeback.
REQ-030 During reset dmem_req, dmem_we, StallM driven 0.

Structure
REQ-031 Shared package holds ResultSrc encodings, funct3 size encodings, FSM state enum.
REQ-032 One sub-module load_align: combinational byte/half select and sign/zero extension of dmem_rdata.

Verification
REQ-033 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall, next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-034 SB addr 0x103, data 0x000000A5, ack after 3 cycles -> be=1000, wdata=0xA5A5A5A5, StallM high 3 cycles, fields stable.
REQ-035 LH addr 0x102, rdata 0x80010000 -> ReadDataW=0xFFFF8001; LHU same -> 0x00008001.
REQ-036 LW addr 0x101 -> dmem_req never 1, misaligned_err pulses once, RegWriteW=0.
REQ-037 TIMEOUT=4, store never acked -> StallM high 4 cycles, timeout_err pulse, dmem_req low after, IDLE.
REQ-038 Reset asserted during WAIT -> next cycle dmem_req=0, StallM=0, W outputs all 0.
